// File: rtl/img_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | img_loader_if : pixel stream, frame memory and accelerator handshake |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface img_loader_if;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_last;
  logic        pix_ready;
  logic [15:0] addr;
  logic [31:0] dataW;
  logic        en;
  logic        we;
  logic        start;
  logic        finish;
  logic        frame_done;
  logic        err;

  // master: pixel source / memory / accelerator environment
  modport master (
    output pix_data, pix_valid, pix_last, finish,
    input  pix_ready, addr, dataW, en, we, start, frame_done, err
  );

  // slave: the loader itself
  modport slave (
    input  pix_data, pix_valid, pix_last, finish,
    output pix_ready, addr, dataW, en, we, start, frame_done, err
  );
endinterface
`default_nettype wire

// File: rtl/img_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | img_loader : packs raster pixel bytes into 32-bit words, writes the  |
// | frame to memory, then launches the accelerator and waits for it.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module img_loader #(
  parameter int IMG_WORDS = 25344,
  parameter int BASE_ADDR = 0
) (
  input wire logic    clk,
  input wire logic    reset,
  img_loader_if.slave bus
);

  localparam int              WC_W      = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(IMG_WORDS - 1);

  localparam logic [2:0] FILL     = 3'd0;
  localparam logic [2:0] WRITE    = 3'd1;
  localparam logic [2:0] KICK     = 3'd2;
  localparam logic [2:0] WAIT_ACC = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]      r_state;
  logic [1:0]      r_byte_cnt;
  logic [WC_W-1:0] r_word_cnt;
  logic [31:0]     r_lanes;
  logic            r_err;

  logic            w_final_byte;
  logic [15:0]     w_addr;

  assign w_final_byte = (r_byte_cnt == 2'd3) && (r_word_cnt == LAST_WORD);
  assign w_addr       = 16'(BASE_ADDR) + 16'(r_word_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= FILL;
      r_byte_cnt <= 2'd0;
      r_word_cnt <= '0;
      r_lanes    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (bus.pix_valid) begin
            r_lanes[{r_byte_cnt, 3'b000} +: 8] <= bus.pix_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // pix_last must coincide exactly with the last byte of the frame
            if (bus.pix_last != w_final_byte) begin
              r_err <= 1'b1;
            end
            if (r_byte_cnt == 2'd3) begin
              r_state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (r_word_cnt == LAST_WORD) begin
            r_word_cnt <= '0;
            r_state    <= KICK;
          end else begin
            r_word_cnt <= r_word_cnt + WC_W'(1);
            r_state    <= FILL;
          end
        end
        KICK: begin
          r_state <= WAIT_ACC;
        end
        WAIT_ACC: begin
          if (bus.finish) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_byte_cnt <= 2'd0;
          r_word_cnt <= '0;
          r_state    <= FILL;
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  // Outputs decode straight from state so reset forces them without a clock
  assign bus.pix_ready  = (r_state == FILL);
  assign bus.en         = (r_state == WRITE);
  assign bus.we         = (r_state == WRITE);
  assign bus.addr       = (r_state == WRITE) ? w_addr  : 16'd0;
  assign bus.dataW      = (r_state == WRITE) ? r_lanes : 32'd0;
  assign bus.start      = (r_state == KICK);
  assign bus.frame_done = (r_state == DONE);
  assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_img_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_img_loader : randomized frames checked against a frame-level model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_img_loader;
  localparam int WORDS = 4;
  localparam int NB    = WORDS * 4;
  localparam int BASE  = 0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  img_loader_if bus();

  img_loader #(.IMG_WORDS(WORDS), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed bus activity, stamped with the cycle number
  logic [15:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          start_q[$];
  int          done_q[$];
  int          idle_viol = 0;

  always @(negedge clk) begin
    if (bus.en === 1'b1) begin
      wr_addr_q.push_back(bus.addr);
      wr_data_q.push_back(bus.dataW);
      wr_cyc_q.push_back(cyc);
      if (bus.we !== 1'b1 || bus.pix_ready !== 1'b0) idle_viol++;
    end else if (bus.we !== 1'b0 || bus.addr !== 16'h0 || bus.dataW !== 32'h0) begin
      idle_viol++;
    end
    if ((bus.start === 1'b1 || bus.frame_done === 1'b1) && bus.pix_ready !== 1'b0) idle_viol++;
    if (bus.start === 1'b1) start_q.push_back(cyc);
    if (bus.frame_done === 1'b1) done_q.push_back(cyc);
  end

  // Stimulus and reference model state
  logic [7:0] bytes_q[$];
  bit         last_q[$];
  int         xfer_q[$];
  bit         exp_err   = 1'b0;
  int         last_done = 0;
  int         errors    = 0;
  int         checks    = 0;

  // A frame is clean only if pix_last is on byte NB-1 and nowhere else
  task automatic build_frame(input int n, input int stray_pos, input bit with_last);
    bytes_q.delete();
    last_q.delete();
    for (int i = 0; i < n; i++) begin
      bytes_q.push_back(8'($urandom));
      last_q.push_back((i == stray_pos) || (with_last && i == NB - 1));
      if (last_q[i] != (i == NB - 1)) exp_err = 1'b1;
    end
  endtask

  task automatic drive_bytes(input bit toggle);
    int idx;
    int t;
    idx = 0;
    t   = 0;
    xfer_q.delete();
    while (idx < bytes_q.size() && t < 4000) begin
      @(negedge clk);
      if (toggle && t[0]) begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'($urandom);
        bus.pix_last  = 1'($urandom);
      end else if (bus.pix_ready === 1'b1) begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = bytes_q[idx];
        bus.pix_last  = last_q[idx];
        xfer_q.push_back(cyc);
        idx++;
      end else begin
        bus.pix_valid = 1'($urandom);
        bus.pix_data  = 8'($urandom);
        bus.pix_last  = 1'($urandom);
      end
      t++;
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
    if (idx < bytes_q.size()) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout sent=%0d required=%0d", idx, bytes_q.size());
    end
  endtask

  // Emulated accelerator: finish raised 'delay' cycles after start, or held high beforehand
  task automatic accel(input int delay, input bit pre, output int s_cyc, output int exp_done);
    int t;
    t = 0;
    s_cyc = -100;
    exp_done = -100;
    if (pre) bus.finish = 1'b1;
    while (bus.start !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (bus.start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL start_timeout start=%b required=1", bus.start);
      bus.finish = 1'b0;
    end else begin
      s_cyc = cyc;
      if (pre) begin
        exp_done = s_cyc + 2;
        t = 0;
        while (bus.frame_done !== 1'b1 && t < 50) begin
          @(negedge clk);
          t++;
        end
        bus.finish = 1'b0;
      end else begin
        repeat (delay) @(negedge clk);
        bus.finish = 1'b1;
        exp_done = s_cyc + delay + 1;
        @(negedge clk);
        bus.finish = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'hAA;
    bus.pix_last  = 1'b1;
    bus.finish    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.pix_ready, bus.en, bus.we, bus.start, bus.frame_done, bus.err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=100000",
               {bus.pix_ready, bus.en, bus.we, bus.start, bus.frame_done, bus.err});
    end
    checks++;
    if (bus.addr !== 16'h0 || bus.dataW !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus addr=%h dataW=%h required 0", bus.addr, bus.dataW);
    end
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
    bus.finish    = 1'b0;
    reset         = 1'b1;
    exp_err       = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.pix_ready !== 1'b1 || bus.en !== 1'b0) begin
      errors++;
      $display("FAIL reset_release pix_ready=%b en=%b required 1/0", bus.pix_ready, bus.en);
    end
  endtask

  // Four bytes 11 22 33 44 lead a continuous frame; finish 10 cycles after start
  task automatic test_first_frame();
    int wb, sb, db, vb, s, d;
    logic [31:0] exp_w;
    wb = wr_addr_q.size(); sb = start_q.size(); db = done_q.size(); vb = idle_viol;
    build_frame(NB, -1, 1'b1);
    bytes_q[0] = 8'h11; bytes_q[1] = 8'h22; bytes_q[2] = 8'h33; bytes_q[3] = 8'h44;
    drive_bytes(1'b0);
    accel(10, 1'b0, s, d);
    last_done = d;
    checks++;
    if (wr_addr_q.size() <= wb || wr_addr_q[wb] !== 16'h0 || wr_data_q[wb] !== 32'h44332211
        || wr_cyc_q[wb] != xfer_q[3] + 1) begin
      errors++;
      $display("FAIL first_word addr=%h data=%h cyc=%0d required addr=0000 data=44332211 cyc=%0d",
               wr_addr_q[wb], wr_data_q[wb], wr_cyc_q[wb], xfer_q[3] + 1);
    end
    for (int w = 0; w < WORDS; w++) begin
      exp_w = {bytes_q[4*w+3], bytes_q[4*w+2], bytes_q[4*w+1], bytes_q[4*w]};
      checks++;
      if (wr_addr_q[wb+w] !== 16'(BASE + w) || wr_data_q[wb+w] !== exp_w
          || wr_cyc_q[wb+w] != xfer_q[4*w+3] + 1) begin
        errors++;
        $display("FAIL frame_word%0d addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                 w, wr_addr_q[wb+w], wr_data_q[wb+w], wr_cyc_q[wb+w], 16'(BASE + w), exp_w, xfer_q[4*w+3] + 1);
      end
    end
    checks++;
    if (wr_addr_q.size() - wb != WORDS) begin
      errors++;
      $display("FAIL frame_write_count got=%0d required=%0d", wr_addr_q.size() - wb, WORDS);
    end
    checks++;
    if (xfer_q[NB-1] - xfer_q[0] != 5 * WORDS - 2) begin
      errors++;
      $display("FAIL throughput span=%0d required=%0d", xfer_q[NB-1] - xfer_q[0], 5 * WORDS - 2);
    end
    checks++;
    if (start_q.size() - sb != 1 || start_q[sb] != xfer_q[NB-1] + 2) begin
      errors++;
      $display("FAIL start_latency count=%0d cyc=%0d required count=1 cyc=%0d",
               start_q.size() - sb, start_q[sb], xfer_q[NB-1] + 2);
    end
    checks++;
    if (done_q.size() - db != 1 || done_q[db] != d) begin
      errors++;
      $display("FAIL frame_done count=%0d cyc=%0d required count=1 cyc=%0d", done_q.size() - db, done_q[db], d);
    end
    checks++;
    if (bus.err !== exp_err || idle_viol != vb) begin
      errors++;
      $display("FAIL frame_err_idle err=%b viol=%0d required err=%b viol=0", bus.err, idle_viol - vb, exp_err);
    end
  endtask

  // Next frame starts the cycle after frame_done; finish already high at WAIT_ACC entry
  task automatic test_back_to_back();
    int wb, sb, db, s, d;
    logic [31:0] exp_w;
    wb = wr_addr_q.size(); sb = start_q.size(); db = done_q.size();
    build_frame(NB, -1, 1'b1);
    drive_bytes(1'b0);
    accel(0, 1'b1, s, d);
    checks++;
    if (xfer_q[0] != last_done + 1) begin
      errors++;
      $display("FAIL b2b_first_accept cyc=%0d required=%0d", xfer_q[0], last_done + 1);
    end
    for (int w = 0; w < WORDS; w++) begin
      exp_w = {bytes_q[4*w+3], bytes_q[4*w+2], bytes_q[4*w+1], bytes_q[4*w]};
      checks++;
      if (wr_addr_q[wb+w] !== 16'(BASE + w) || wr_data_q[wb+w] !== exp_w) begin
        errors++;
        $display("FAIL b2b_word%0d addr=%h data=%h required addr=%h data=%h",
                 w, wr_addr_q[wb+w], wr_data_q[wb+w], 16'(BASE + w), exp_w);
      end
    end
    checks++;
    if (start_q.size() - sb != 1 || done_q.size() - db != 1 || done_q[db] != d) begin
      errors++;
      $display("FAIL b2b_done starts=%0d dones=%0d cyc=%0d required 1/1 cyc=%0d",
               start_q.size() - sb, done_q.size() - db, done_q[db], d);
    end
  endtask

  // pix_valid alternates 1/0: identical words, nothing lost or duplicated
  task automatic test_gappy();
    int wb, sb, s, d;
    logic [31:0] exp_w;
    wb = wr_addr_q.size(); sb = start_q.size();
    build_frame(NB, -1, 1'b1);
    drive_bytes(1'b1);
    accel(int'($urandom_range(1, 20)), 1'b0, s, d);
    for (int w = 0; w < WORDS; w++) begin
      exp_w = {bytes_q[4*w+3], bytes_q[4*w+2], bytes_q[4*w+1], bytes_q[4*w]};
      checks++;
      if (wr_addr_q[wb+w] !== 16'(BASE + w) || wr_data_q[wb+w] !== exp_w
          || wr_cyc_q[wb+w] != xfer_q[4*w+3] + 1) begin
        errors++;
        $display("FAIL gappy_word%0d addr=%h data=%h required addr=%h data=%h",
                 w, wr_addr_q[wb+w], wr_data_q[wb+w], 16'(BASE + w), exp_w);
      end
    end
    checks++;
    if (wr_addr_q.size() - wb != WORDS || start_q.size() - sb != 1 || start_q[sb] != xfer_q[NB-1] + 2) begin
      errors++;
      $display("FAIL gappy_frame writes=%0d starts=%0d required %0d/1", wr_addr_q.size() - wb, start_q.size() - sb, WORDS);
    end
  endtask

  // Stray pix_last on byte 5 flags err; frame completes and err stays set
  task automatic test_bad_last();
    int wb, sb, s, d;
    logic [31:0] exp_w;
    wb = wr_addr_q.size(); sb = start_q.size();
    build_frame(NB, 4, 1'b1);
    drive_bytes(1'b0);
    accel(int'($urandom_range(1, 8)), 1'b0, s, d);
    for (int w = 0; w < WORDS; w++) begin
      exp_w = {bytes_q[4*w+3], bytes_q[4*w+2], bytes_q[4*w+1], bytes_q[4*w]};
      checks++;
      if (wr_data_q[wb+w] !== exp_w) begin
        errors++;
        $display("FAIL badlast_word%0d data=%h required=%h", w, wr_data_q[wb+w], exp_w);
      end
    end
    checks++;
    if (bus.err !== 1'b1 || exp_err !== 1'b1 || start_q.size() - sb != 1) begin
      errors++;
      $display("FAIL badlast_err err=%b starts=%0d required err=1 starts=1", bus.err, start_q.size() - sb);
    end
    build_frame(NB, -1, 1'b1);
    drive_bytes(1'b0);
    accel(3, 1'b0, s, d);
    checks++;
    if (bus.err !== exp_err) begin
      errors++;
      $display("FAIL err_sticky err=%b required=%b", bus.err, exp_err);
    end
  endtask

  // Frame without pix_last: err set, frame still written and started
  task automatic test_missing_last();
    int wb, sb, s, d;
    logic [31:0] exp_w;
    do_reset();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared err=%b required=0", bus.err);
    end
    wb = wr_addr_q.size(); sb = start_q.size();
    build_frame(NB, -1, 1'b0);
    drive_bytes(1'b0);
    accel(2, 1'b0, s, d);
    for (int w = 0; w < WORDS; w++) begin
      exp_w = {bytes_q[4*w+3], bytes_q[4*w+2], bytes_q[4*w+1], bytes_q[4*w]};
      checks++;
      if (wr_addr_q[wb+w] !== 16'(BASE + w) || wr_data_q[wb+w] !== exp_w) begin
        errors++;
        $display("FAIL nolast_word%0d addr=%h data=%h required addr=%h data=%h",
                 w, wr_addr_q[wb+w], wr_data_q[wb+w], 16'(BASE + w), exp_w);
      end
    end
    checks++;
    if (bus.err !== exp_err || start_q.size() - sb != 1) begin
      errors++;
      $display("FAIL nolast_err err=%b starts=%0d required err=%b starts=1", bus.err, start_q.size() - sb, exp_err);
    end
  endtask

  // Reset in WAIT_ACC and mid-fill: immediate abort, restart at word 0
  task automatic test_reset_mid();
    int wb, sb, db, t, s, d;
    logic [31:0] exp_w;
    build_frame(NB, 2, 1'b1);
    drive_bytes(1'b0);
    t = 0;
    while (bus.start !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_err err=%b required=1", bus.err);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    exp_err = 1'b0;
    #1;
    checks++;
    if ({bus.pix_ready, bus.en, bus.we, bus.start, bus.frame_done, bus.err} !== 6'b100000
        || bus.addr !== 16'h0 || bus.dataW !== 32'h0) begin
      errors++;
      $display("FAIL async_reset ctrl=%b addr=%h dataW=%h required 100000/0/0",
               {bus.pix_ready, bus.en, bus.we, bus.start, bus.frame_done, bus.err}, bus.addr, bus.dataW);
    end
    wb = wr_addr_q.size(); sb = start_q.size(); db = done_q.size();
    bus.finish = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    bus.finish = 1'b0;
    checks++;
    if (wr_addr_q.size() != wb || start_q.size() != sb || done_q.size() != db || bus.pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_quiet writes=%0d starts=%0d dones=%0d ready=%b required 0/0/0/1",
               wr_addr_q.size() - wb, start_q.size() - sb, done_q.size() - db, bus.pix_ready);
    end
    build_frame(6, -1, 1'b0);
    drive_bytes(1'b0);
    reset = 1'b0;
    wb = wr_addr_q.size();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != wb) begin
      errors++;
      $display("FAIL abort_fill writes=%0d required=0", wr_addr_q.size() - wb);
    end
    sb = start_q.size();
    build_frame(NB, -1, 1'b1);
    drive_bytes(1'b0);
    accel(5, 1'b0, s, d);
    for (int w = 0; w < WORDS; w++) begin
      exp_w = {bytes_q[4*w+3], bytes_q[4*w+2], bytes_q[4*w+1], bytes_q[4*w]};
      checks++;
      if (wr_addr_q[wb+w] !== 16'(BASE + w) || wr_data_q[wb+w] !== exp_w) begin
        errors++;
        $display("FAIL restart_word%0d addr=%h data=%h required addr=%h data=%h",
                 w, wr_addr_q[wb+w], wr_data_q[wb+w], 16'(BASE + w), exp_w);
      end
    end
    checks++;
    if (bus.err !== exp_err || start_q.size() - sb != 1) begin
      errors++;
      $display("FAIL restart_frame err=%b starts=%0d required err=%b starts=1", bus.err, start_q.size() - sb, exp_err);
    end
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'h00;
    bus.pix_last  = 1'b0;
    bus.finish    = 1'b0;
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_gappy();
    test_bad_last();
    test_missing_last();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/img_loader.md
IMG_LOADER -- requirements
Module: img_loader

Interface
REQ-001 Parameter IMG_WORDS, default 25344, number of 32-bit words per frame (352x288 pixels / 4).
REQ-002 Parameter BASE_ADDR, default 0, word address of the first frame word in memory.
REQ-003 clk  input  1  the clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 pix_data  input  8  grayscale pixel byte, raster order.
REQ-006 pix_valid  input  1  pix_data is valid this cycle.
REQ-007 pix_last  input  1  marks the final pixel of the frame; qualified by pix_valid.
REQ-008 pix_ready  output  1  loader accepts a pixel this cycle; transfer = pix_valid & pix_ready.
REQ-009 addr  output  16  memory word address.
REQ-010 dataW  output  32  memory write data.
REQ-011 en  output  1  memory request.
REQ-012 we  output  1  memory write enable.
REQ-013 start  output  1  one-cycle pulse that launches the edge-detection accelerator.
REQ-014 finish  input  1  accelerator completion level.
REQ-015 frame_done  output  1  one-cycle pulse when the accelerator has finished the loaded frame.
REQ-016 err  output  1  sticky framing-error flag.

Function
REQ-017 The FSM SHALL have exactly the states FILL, WRITE, KICK, WAIT_ACC and DONE.
REQ-018 FILL: pix_ready=1, en=0, we=0; each transfer stores the byte in lane byte_cnt (lane 0 = dataW[7:0], lane 3 = dataW[31:24]), then increments byte_cnt (2 bits).
REQ-019 FILL: a transfer with byte_cnt==3 SHALL move the FSM to WRITE on the next edge.
REQ-020 WRITE: exactly one cycle; pix_ready=0, en=1, we=1, addr=BASE_ADDR+word_cnt (16-bit, truncated), dataW={lane3,lane2,lane1,lane0}.
REQ-021 WRITE exit: if word_cnt==IMG_WORDS-1 go to KICK and clear word_cnt; otherwise increment word_cnt and go to FILL.
REQ-022 KICK: start=1 for exactly one cycle, pix_ready=0; next state WAIT_ACC.
REQ-023 WAIT_ACC: pix_ready=0, en=0; stay until finish=1, then go to DONE.
REQ-024 DONE: frame_done=1 for one cycle; next state FILL with byte_cnt=0 and word_cnt=0.
REQ-025 Outside WRITE, addr and dataW SHALL be 0, and en and we SHALL be 0.
REQ-026 pix_last on a transfer that is not byte 3 of word IMG_WORDS-1 SHALL set err; the byte is stored normally.
REQ-027 A missing pix_last on the final frame byte SHALL set err; the frame proceeds normally.
REQ-028 err SHALL remain 1 until reset.
REQ-029 pix_valid=0 in FILL: no state change, byte_cnt held; gaps of any length are allowed.
REQ-030 pix_valid and pix_data SHALL be ignored in every state except FILL.
REQ-031 Throughput SHALL be 5 cycles per word with continuous pix_valid.
REQ-032 Latency from the final-byte transfer SHALL be: start asserted 2 cycles later (WRITE, then KICK).
REQ-033 If finish is already 1 on entry to WAIT_ACC, DONE SHALL follow on the next cycle.

Reset
REQ-034 With reset=0, the FSM SHALL be in FILL and byte_cnt, word_cnt, lanes and err SHALL be 0.
REQ-035 With reset=0, outputs SHALL be: pix_ready=1, en=0, we=0, addr=0, dataW=0, start=0, frame_done=0, err=0.
REQ-036 Reset asserted mid-frame SHALL abort the frame immediately; no further write or start occurs, and loading restarts at word 0.

Verification
REQ-037 Pixel bytes 0x11,0x22,0x33,0x44 continuous -> next cycle: en=we=1, addr=0, dataW=0x44332211.
REQ-038 Full frame (IMG_WORDS=4 override, 16 bytes, pix_last on the 16th) -> writes to addr 0..3, start pulse 2 cycles after the last byte, err=0.
REQ-039 finish raised 10 cycles after start -> frame_done pulses in the cycle after finish is sampled; the next byte is accepted into word 0.
REQ-040 pix_last on byte 5 -> err=1 and stays 1; the frame still completes and start pulses.
REQ-041 pix_valid toggled 1/0 every cycle -> same write data and addresses as the continuous case; no byte lost or duplicated.
REQ-042 reset=0 asserted during WAIT_ACC -> all outputs reach their reset values asynchronously; after release, pix_ready=1 and the next write goes to addr BASE_ADDR.
